// File: rtl/zero_io_pkg.sv
// rtl/zero_io_pkg.sv - shared element type and width helpers for the zero machine I/O unit
package zero_io_pkg;

    localparam int MemoryElementWidthDefault = 12;

    typedef logic [MemoryElementWidthDefault-1:0] element_t;

    // Channel-select width; a single channel still needs a 1-bit select port.
    function automatic int cw_of(input int nchannels);
        return (nchannels > 1) ? $clog2(nchannels) : 1;
    endfunction

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int iw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ow_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/zero_io_fifo.sv
// rtl/zero_io_fifo.sv - parametrised FIFO with count and optional overwrite-oldest mode
module zero_io_fifo
    import zero_io_pkg::*;
#(
    parameter int  W         = MemoryElementWidthDefault,
    parameter int  DEPTH     = 4,
    parameter bit  OVERWRITE = 1'b0,
    localparam int CNTW      = iw_of(DEPTH),
    localparam int PW        = ptr_w(DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  logic [W-1:0]    push_data,
    input  logic            pop,
    output logic [W-1:0]    head_data,
    output logic [CNTW-1:0] count,
    output logic            full
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;
    logic          drop_oldest;

    // Depth need not be a power of two, so wrap by compare rather than truncation.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (count == CNTW'(DEPTH));
    assign empty       = (count == '0);
    assign pop_ok      = pop && !empty;
    assign push_ok     = push && (!full || OVERWRITE);
    assign drop_oldest = push_ok && full && !pop_ok;
    assign head_data   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop_ok || drop_oldest) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (push_ok && !pop_ok && !drop_oldest) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/zero_io_channels.sv
// rtl/zero_io_channels.sv - multi-channel input FIFOs and output ring for the zero machine
module zero_io_channels
    import zero_io_pkg::*;
#(
    parameter int  MemoryElementWidth = MemoryElementWidthDefault,
    parameter int  NChannels          = 2,
    parameter int  NIn                = 4,
    parameter int  NOut               = 5,
    parameter bit  OutWrap            = 1'b1,
    localparam int W                  = MemoryElementWidth,
    localparam int CW                 = cw_of(NChannels),
    localparam int IW                 = iw_of(NIn),
    localparam int OW                 = ow_of(NOut)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ld_valid,
    input  logic [CW-1:0] ld_chan,
    input  logic [W-1:0]  ld_data,
    output logic          ld_ready,
    input  logic          in_req,
    input  logic [CW-1:0] in_chan,
    output logic          in_ack,
    output logic          in_hit,
    output logic [W-1:0]  in_data,
    output logic [IW-1:0] in_size,
    input  logic          out_valid,
    input  logic [W-1:0]  out_data,
    output logic          out_ready,
    output logic          dr_valid,
    output logic [W-1:0]  dr_data,
    input  logic          dr_ready,
    output logic          overflow
);

    logic [IW-1:0] ch_count [NChannels];
    logic [W-1:0]  ch_head  [NChannels];
    logic          ch_full  [NChannels];

    logic          sel_ld_full;
    logic [IW-1:0] sel_in_count;
    logic [W-1:0]  sel_in_head;
    logic          in_avail;

    logic [OW-1:0] out_count;
    logic          out_full;
    logic          out_push;
    logic          drain_take;
    logic          ovf_set;

    genvar gi;
    generate
        for (gi = 0; gi < NChannels; gi++) begin : g_in
            logic ch_push;
            logic ch_pop;

            assign ch_push = ld_valid && ld_ready && (ld_chan == CW'(gi));
            assign ch_pop  = in_req && (in_chan == CW'(gi));

            zero_io_fifo #(
                .W         (W),
                .DEPTH     (NIn),
                .OVERWRITE (1'b0)
            ) u_in_fifo (
                .clock     (clock),
                .reset_n   (reset_n),
                .push      (ch_push),
                .push_data (ld_data),
                .pop       (ch_pop),
                .head_data (ch_head[gi]),
                .count     (ch_count[gi]),
                .full      (ch_full[gi])
            );
        end
    endgenerate

    // A select beyond NChannels reads as an empty, never-ready channel.
    always_comb begin
        sel_ld_full  = 1'b1;
        sel_in_count = '0;
        sel_in_head  = '0;
        for (int i = 0; i < NChannels; i++) begin
            if (ld_chan == CW'(i)) begin
                sel_ld_full = ch_full[i];
            end
            if (in_chan == CW'(i)) begin
                sel_in_count = ch_count[i];
                sel_in_head  = ch_head[i];
            end
        end
    end

    assign ld_ready = !sel_ld_full;
    assign in_size  = sel_in_count;
    assign in_avail = (sel_in_count != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ack  <= 1'b0;
            in_hit  <= 1'b0;
            in_data <= '0;
        end else begin
            in_ack <= in_req;
            in_hit <= in_req && in_avail;
            if (in_req && in_avail) begin
                in_data <= sel_in_head;
            end
        end
    end

    assign out_ready  = OutWrap ? 1'b1 : !out_full;
    assign out_push   = out_valid && out_ready;
    assign dr_valid   = (out_count != '0);
    assign drain_take = dr_valid && dr_ready;
    // A same-cycle drain frees the slot, so only an unserviced full write loses data.
    assign ovf_set    = OutWrap && out_push && out_full && !drain_take;

    zero_io_fifo #(
        .W         (W),
        .DEPTH     (NOut),
        .OVERWRITE (OutWrap)
    ) u_out_ring (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (out_push),
        .push_data (out_data),
        .pop       (dr_ready),
        .head_data (dr_data),
        .count     (out_count),
        .full      (out_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end
    end

endmodule
